multicycle_control_unit: RTL and testbench

Multicycle RV32I control FSM that replaces the single-cycle combinational decoder. It sequences each instruction over 3–5 cycles through a shared-memory, shared-ALU datapath. It stalls on a memory ready handshake and traps undecodable instructions. It drives the PC, instruction-register, memory, register-file and ALU mux controls of the multicycle datapath.

---
 rtl/cu_pkg.sv | 50 +++++
 rtl/alu_decoder.sv | 50 +++++
 rtl/multicycle_control_unit.sv | 165 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcodes, ALU operation encodings and datapath mux selects.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode plus a valid flag for undecodable
// instructions. CU_BRANCH_EXT_EN widens the legal branch funct3 set.
module alu_decoder
  import cu_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [2:0] o_alu_control,
  output logic       o_valid
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_valid       = 1'b0;
    case (i_op)
      OP_LOAD, OP_STORE, OP_JAL: o_valid = 1'b1;
      OP_RTYPE: begin
        case ({i_funct7, i_funct3})
          10'b0000000_000: begin o_alu_control = ALU_ADD; o_valid = 1'b1; end
          10'b0100000_000: begin o_alu_control = ALU_SUB; o_valid = 1'b1; end
          10'b0000000_111: begin o_alu_control = ALU_AND; o_valid = 1'b1; end
          10'b0000000_110: begin o_alu_control = ALU_OR;  o_valid = 1'b1; end
          10'b0000000_010: begin o_alu_control = ALU_SLT; o_valid = 1'b1; end
          default: ;
        endcase
      end
      OP_ITYPE: begin
        case (i_funct3)
          3'b000: begin o_alu_control = ALU_ADD; o_valid = 1'b1; end
          3'b111: begin o_alu_control = ALU_AND; o_valid = 1'b1; end
          3'b110: begin o_alu_control = ALU_OR;  o_valid = 1'b1; end
          3'b010: begin o_alu_control = ALU_SLT; o_valid = 1'b1; end
          default: ;
        endcase
      end
      OP_BRANCH: begin
        o_alu_control = ALU_SUB;
`ifdef CU_BRANCH_EXT_EN
        o_valid = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                  (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
`else
        o_valid = (i_funct3 == 3'b000);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM for a shared-memory, shared-ALU datapath.
// Optional CU_BRANCH_EXT_EN adds bne/blt/bge on top of beq.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned ALUC_W      = 3,
  parameter bit          TRAP_STICKY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              zero,
  input  logic              lt,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              IRWrite,
  output logic              MemWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [1:0]        ImmSrc,
  output logic              RegWrite,
  output logic              illegal
);

  state_t     r_state, w_next;
  logic [2:0] w_dec_alu, w_alu;
  logic       w_dec_valid, w_take;

  alu_decoder u_alu_decoder (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .o_alu_control (w_dec_alu),
    .o_valid       (w_dec_valid)
  );

`ifdef CU_BRANCH_EXT_EN
  always_comb begin
    case (funct3)
      3'b001:  w_take = ~zero;
      3'b100:  w_take = lt;
      3'b101:  w_take = ~lt;
      default: w_take = zero;
    endcase
  end
`else
  logic w_unused_lt;
  assign w_unused_lt = lt;
  assign w_take      = zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    w_alu     = ALU_ADD;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (!w_dec_valid) w_next = S_TRAP;
        else begin
          case (op)
            OP_LOAD, OP_STORE: w_next = S_MEMADR;
            OP_RTYPE:          w_next = S_EXECR;
            OP_ITYPE:          w_next = S_EXECI;
            OP_BRANCH:         w_next = S_BRANCH;
            OP_JAL:            w_next = S_JAL;
            default:           w_next = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        w_alu   = w_dec_alu;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        w_alu   = ALU_SUB;
        PCWrite = w_take;
        w_next  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = TRAP_STICKY ? S_TRAP : S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset suppresses strobes only; mux selects still follow the current state.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  assign ALUControl = ALUC_W'(w_alu);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench: per-cycle output signatures for each
// instruction class, stalls, traps (sticky and one-shot) and reset abort.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset, zero, lt, mem_ready;
  logic [6:0] op, funct7;
  logic [2:0] funct3;

  logic       pcw0, adr0, irw0, mw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic       pcw1, adr1, irw1, mw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;

  logic [16:0] w_sig0, w_sig1;
  assign w_sig0 = {pcw0, adr0, irw0, mw0, rs0, sa0, sb0, alu0, imm0, rw0, ill0};
  assign w_sig1 = {pcw1, adr1, irw1, mw1, rs1, sa1, sb1, alu1, imm1, rw1, ill1};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] q_exp[$];
  logic        q_mr[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALUC_W(3), .TRAP_STICKY(1'b1)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .IRWrite(irw0), .MemWrite(mw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0),
    .ImmSrc(imm0), .RegWrite(rw0), .illegal(ill0)
  );

  multicycle_control_unit #(.ALUC_W(3), .TRAP_STICKY(1'b0)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .PCWrite(pcw1), .AdrSrc(adr1), .IRWrite(irw1), .MemWrite(mw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1),
    .ImmSrc(imm1), .RegWrite(rw1), .illegal(ill1)
  );

  // Signature: {PCWrite,AdrSrc,IRWrite,MemWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,illegal}
  function automatic logic [16:0] pk(input logic pcw, input logic adr, input logic irw,
                                     input logic mw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic rw, input logic ill);
    return {pcw, adr, irw, mw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  function automatic logic [16:0] fetch(input logic mr, input logic [1:0] imm);
    return pk(mr, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 3'b010, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] decode(input logic [1:0] imm);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [16:0] trap(input logic [1:0] imm);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, imm, 1'b0, 1'b1);
  endfunction

  task automatic add(input logic [16:0] e, input logic m);
    q_exp.push_back(e);
    q_mr.push_back(m);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q_exp.delete();
    q_mr.delete();
  endtask

  task automatic test_reset();
    op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (w_sig0 !== pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0)) begin
      $display("FAIL reset_hold: got %h want %h", w_sig0,
               pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0));
      n_fail++;
    end
    n_cmp++;
    if (w_sig1 !== w_sig0 || w_sig1 !== fetch(1'b0, 2'b00)) begin
      $display("FAIL reset_hold_dut1: got %h want %h", w_sig1, fetch(1'b0, 2'b00));
      n_fail++;
    end
    reset = 1'b0; #1;
    n_cmp++;
    if (w_sig0 !== fetch(1'b1, 2'b00)) begin
      $display("FAIL reset_release: got %h want %h", w_sig0, fetch(1'b1, 2'b00));
      n_fail++;
    end
  endtask

  task automatic run_queue(input string name);
    foreach (q_exp[i]) begin
      mem_ready = q_mr[i]; #1;
      n_cmp++;
      if (w_sig0 !== q_exp[i]) begin
        $display("FAIL %s c%0d: got %h want %h", name, i, w_sig0, q_exp[i]);
        n_fail++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype(input string name, input logic [6:0] f7, input logic [2:0] f3,
                            input logic [2:0] alu, input int unsigned fstall);
    do_reset();
    op = 7'b0110011; funct3 = f3; funct7 = f7;
    repeat (fstall) add(fetch(1'b0, 2'b00), 1'b0);
    add(fetch(1'b1, 2'b00), 1'b1);
    add(decode(2'b00), 1'b0);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 1'b0, 1'b0), 1'b0);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b1, 1'b0), 1'b0);
    add(fetch(1'b1, 2'b00), 1'b1);
    run_queue(name);
  endtask

  task automatic test_itype(input string name, input logic [2:0] f3, input logic [2:0] alu);
    do_reset();
    op = 7'b0010011; funct3 = f3; funct7 = 7'b0100000;
    add(fetch(1'b1, 2'b00), 1'b1);
    add(decode(2'b00), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 1'b0, 1'b0), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b1, 1'b0), 1'b1);
    add(fetch(1'b1, 2'b00), 1'b1);
    run_queue(name);
  endtask

  task automatic test_illegal_funct();
    do_reset();
    op = 7'b0110011; funct3 = 3'b111; funct7 = 7'b0100000;
    add(fetch(1'b1, 2'b00), 1'b1);
    add(decode(2'b00), 1'b1);
    add(trap(2'b00), 1'b1);
    add(trap(2'b00), 1'b1);
    run_queue("bad_funct");
  endtask

  task automatic test_lw();
    do_reset();
    op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000;
    add(fetch(1'b1, 2'b00), 1'b1);
    add(decode(2'b00), 1'b0);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0), 1'b0);
    add(pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0), 1'b0);
    add(pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0), 1'b0);
    add(pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b010, 2'b00, 1'b1, 1'b0), 1'b0);
    add(fetch(1'b1, 2'b00), 1'b1);
    run_queue("lw");
  endtask

  task automatic test_sw();
    do_reset();
    op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
    add(fetch(1'b1, 2'b01), 1'b1);
    add(decode(2'b01), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b01, 1'b0, 1'b0), 1'b1);
    repeat (3) add(pk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0), 1'b0);
    add(pk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0), 1'b1);
    add(fetch(1'b1, 2'b01), 1'b1);
    run_queue("sw");
  endtask

  task automatic test_beq(input string name, input logic z);
    do_reset();
    op = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; zero = z;
    add(fetch(1'b1, 2'b10), 1'b1);
    add(decode(2'b10), 1'b1);
    add(pk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b110, 2'b10, 1'b0, 1'b0), 1'b1);
    add(fetch(1'b1, 2'b10), 1'b1);
    run_queue(name);
  endtask

  task automatic test_jal();
    do_reset();
    op = 7'b1101111; funct3 = 3'b000; funct7 = 7'b0000000;
    add(fetch(1'b1, 2'b11), 1'b1);
    add(decode(2'b11), 1'b1);
    add(pk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b010, 2'b11, 1'b0, 1'b0), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b11, 1'b1, 1'b0), 1'b1);
    add(fetch(1'b1, 2'b11), 1'b1);
    run_queue("jal");
  endtask

  task automatic test_trap();
    logic [16:0] e0, e1;
    do_reset();
    op = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0000000;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'b1; #1;
      e0 = (i == 0) ? fetch(1'b1, 2'b00) : (i == 1) ? decode(2'b00) : trap(2'b00);
      e1 = (i % 3 == 0) ? fetch(1'b1, 2'b00) : (i % 3 == 1) ? decode(2'b00) : trap(2'b00);
      n_cmp++;
      if (w_sig0 !== e0) begin
        $display("FAIL trap_sticky c%0d: got %h want %h", i, w_sig0, e0);
        n_fail++;
      end
      n_cmp++;
      if (w_sig1 !== e1) begin
        $display("FAIL trap_pulse c%0d: got %h want %h", i, w_sig1, e1);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    n_cmp++;
    if (w_sig0 !== fetch(1'b1, 2'b00)) begin
      $display("FAIL trap_reset: got %h want %h", w_sig0, fetch(1'b1, 2'b00));
      n_fail++;
    end
  endtask

  task automatic test_reset_memwrite();
    do_reset();
    op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
    add(fetch(1'b1, 2'b01), 1'b1);
    add(decode(2'b01), 1'b1);
    add(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b010, 2'b01, 1'b0, 1'b0), 1'b1);
    add(pk(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0), 1'b0);
    run_queue("rst_mw_pre");
    reset = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++;
    if (w_sig0 !== pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0)) begin
      $display("FAIL rst_mw_abort: got %h want %h", w_sig0,
               pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 2'b01, 1'b0, 1'b0));
      n_fail++;
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    n_cmp++;
    if (w_sig0 !== fetch(1'b0, 2'b01)) begin
      $display("FAIL rst_mw_fetch: got %h want %h", w_sig0, fetch(1'b0, 2'b01));
      n_fail++;
    end
  endtask

  task automatic test_branch_ext(input string name, input logic [2:0] f3,
                                 input logic z, input logic l, input logic take);
    do_reset();
    op = 7'b1100011; funct3 = f3; funct7 = 7'b0000000; zero = z; lt = l;
    add(fetch(1'b1, 2'b10), 1'b1);
    add(decode(2'b10), 1'b1);
`ifdef CU_BRANCH_EXT_EN
    add(pk(take, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b110, 2'b10, 1'b0, 1'b0), 1'b1);
    add(fetch(1'b1, 2'b10), 1'b1);
`else
    if (take !== z) add(trap(2'b10), 1'b1);
    add(trap(2'b10), 1'b1);
    add(trap(2'b10), 1'b1);
`endif
    run_queue(name);
  endtask

  initial begin
    op = '0; funct3 = '0; funct7 = '0;
    reset = 1'b1; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype("add", 7'b0000000, 3'b000, 3'b010, 0);
    test_rtype("sub", 7'b0100000, 3'b000, 3'b110, 2);
    test_rtype("and", 7'b0000000, 3'b111, 3'b000, 0);
    test_rtype("or",  7'b0000000, 3'b110, 3'b001, 0);
    test_rtype("slt", 7'b0000000, 3'b010, 3'b101, 1);
    test_itype("addi", 3'b000, 3'b010);
    test_itype("ori",  3'b110, 3'b001);
    test_itype("slti", 3'b010, 3'b101);
    test_illegal_funct();
    test_lw();
    test_sw();
    test_beq("beq_taken", 1'b1);
    test_beq("beq_not",   1'b0);
    test_jal();
    test_trap();
    test_reset_memwrite();
    test_branch_ext("bne_z0", 3'b001, 1'b0, 1'b0, 1'b1);
    test_branch_ext("blt_lt", 3'b100, 1'b0, 1'b1, 1'b1);
    test_branch_ext("bge_lt", 3'b101, 1'b1, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
